doorlock_input_ctrl: RTL and testbench

//   Front-end sequencer directly upstream of the door lock core. Synchronises and

---
 rtl/doorlock_input_ctrl.sv | 142 ++++++++++++++
 tb/tb_doorlock_input_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/doorlock_input_ctrl.sv
// doorlock_input_ctrl: debounces SET/CHECK buttons and sequences lock core check, open hold and lockout
module doorlock_input_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int CHECK_WAIT       = 2,
  parameter int OPEN_HOLD_CYCLES = 1000,
  parameter int MAX_FAILS        = 3,
  parameter int LOCKOUT_CYCLES   = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_set,
  input  logic       btn_check,
  input  logic [3:0] sw_num,
  input  logic       door_open,
  output logic [1:0] state,
  output logic [3:0] ps_num,
  output logic       locked_out,
  output logic [7:0] fail_cnt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(CHECK_WAIT + 1);
  localparam int OW = $clog2(OPEN_HOLD_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SET, CHECK, OPEN, LOCKOUT} fsm_t;
  fsm_t          fsm_q, fsm_d;
  logic [1:0]    sync1_q, sync2_q, lvl_q, lvl_d, press_q, press_d;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];
  logic [CW-1:0] wait_q, wait_d;
  logic [OW-1:0] hold_q, hold_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    ps_num_q, ps_num_d;
  logic          locked_q, locked_d;
  logic [7:0]    fail_q, fail_d, fail_inc;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = (sync2_q[i] == lvl_q[i] || dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : dcnt_q[i] + DW'(1);
      lvl_d[i]  = (sync2_q[i] != lvl_q[i] && dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? sync2_q[i] : lvl_q[i];
    end
    press_d = lvl_d & ~lvl_q;
  end
  assign fail_inc = (fail_q >= 8'(MAX_FAILS)) ? 8'(MAX_FAILS) : fail_q + 8'd1;
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    ps_num_d = ps_num_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    wait_d   = '0;
    hold_d   = '0;
    lock_d   = '0;
    case (fsm_q)
      IDLE: begin
        if (press_q[0]) begin
          fsm_d    = SET;
          state_d  = 2'b01;
          ps_num_d = sw_num;
        end else if (press_q[1]) begin
          fsm_d   = CHECK;
          state_d = 2'b10;
        end
      end
      SET: begin
        fsm_d   = IDLE;
        state_d = 2'b00;
      end
      CHECK: begin
        if (wait_q != CW'(CHECK_WAIT - 1)) begin
          wait_d = wait_q + CW'(1);
        end else if (door_open) begin
          fsm_d  = OPEN;
          fail_d = '0;
        end else begin
          fail_d   = fail_inc;
          fsm_d    = (fail_inc == 8'(MAX_FAILS)) ? LOCKOUT : IDLE;
          locked_d = (fail_inc == 8'(MAX_FAILS));
          state_d  = 2'b00;
        end
      end
      OPEN: begin
        if (hold_q != OW'(OPEN_HOLD_CYCLES - 1)) begin
          hold_d = hold_q + OW'(1);
        end else begin
          fsm_d   = IDLE;
          state_d = 2'b00;
        end
      end
      LOCKOUT: begin
        if (lock_q != LW'(LOCKOUT_CYCLES - 1)) begin
          lock_d = lock_q + LW'(1);
        end else begin
          fsm_d    = IDLE;
          locked_d = 1'b0;
          fail_d   = '0;
        end
      end
      default: begin
        fsm_d    = IDLE;
        state_d  = 2'b00;
        locked_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      press_q   <= '0;
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
      fsm_q     <= IDLE;
      wait_q    <= '0;
      hold_q    <= '0;
      lock_q    <= '0;
      state_q   <= 2'b00;
      ps_num_q  <= '0;
      locked_q  <= 1'b0;
      fail_q    <= '0;
    end else begin
      sync1_q   <= {btn_check, btn_set};
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      dcnt_q[0] <= dcnt_d[0];
      dcnt_q[1] <= dcnt_d[1];
      fsm_q     <= fsm_d;
      wait_q    <= wait_d;
      hold_q    <= hold_d;
      lock_q    <= lock_d;
      state_q   <= state_d;
      ps_num_q  <= ps_num_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
    end
  end
  assign state      = state_q;
  assign ps_num     = ps_num_q;
  assign locked_out = locked_q;
  assign fail_cnt   = fail_q;
endmodule

// File: tb/tb_doorlock_input_ctrl.sv
// tb_doorlock_input_ctrl: directed bench for doorlock_input_ctrl with a lock core that opens on code D
module tb_doorlock_input_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_check = 1'b0;
  logic [3:0] sw_num = 4'h0;
  logic       door_open;
  logic [1:0] state;
  logic [3:0] ps_num;
  logic       locked_out;
  logic [7:0] fail_cnt;
  int         errors = 0;
  int         checks = 0;
  doorlock_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CHECK_WAIT(2),
    .OPEN_HOLD_CYCLES(8),
    .MAX_FAILS(3),
    .LOCKOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_set(btn_set),
    .btn_check(btn_check),
    .sw_num(sw_num),
    .door_open(door_open),
    .state(state),
    .ps_num(ps_num),
    .locked_out(locked_out),
    .fail_cnt(fail_cnt)
  );
  assign door_open = (ps_num == 4'hD);
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic all_idle(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(2'b00));
    chk({tag, "_ps"}, 32'(ps_num), 32'(4'h0));
    chk({tag, "_lock"}, 32'(locked_out), 32'(1'b0));
    chk({tag, "_fail"}, 32'(fail_cnt), 32'(8'd0));
  endtask
  task automatic fail_check(input logic [7:0] f, input logic lk);
    btn_check = 1'b1;
    cyc(6);
    chk("fail_pre", 32'(state), 32'(2'b00));
    cyc(1);
    chk("fail_chk0", 32'(state), 32'(2'b10));
    cyc(1);
    chk("fail_chk1", 32'(state), 32'(2'b10));
    cyc(1);
    chk("fail_state", 32'(state), 32'(2'b00));
    chk("fail_cnt", 32'(fail_cnt), 32'(f));
    chk("fail_lock", 32'(locked_out), 32'(lk));
    btn_check = 1'b0;
  endtask
  task automatic press_set(input logic [3:0] code);
    sw_num = code;
    btn_set = 1'b1;
    cyc(7);
    chk("set_state", 32'(state), 32'(2'b01));
    chk("set_ps", 32'(ps_num), 32'(code));
    cyc(1);
    chk("set_done", 32'(state), 32'(2'b00));
    btn_set = 1'b0;
    cyc(8);
  endtask
  initial begin
    cyc(3);
    all_idle("reset");
    rst_n = 1'b1;
    cyc(2);
    // 1: SET with code D, seven edges from press to state=01
    sw_num = 4'hD;
    btn_set = 1'b1;
    cyc(6);
    chk("t1_pre", 32'(state), 32'(2'b00));
    cyc(1);
    chk("t1_set", 32'(state), 32'(2'b01));
    chk("t1_ps", 32'(ps_num), 32'(4'hD));
    cyc(1);
    chk("t1_post", 32'(state), 32'(2'b00));
    cyc(2);
    btn_set = 1'b0;
    cyc(10);
    chk("t1_held", 32'(state), 32'(2'b00));
    chk("t1_ps_hold", 32'(ps_num), 32'(4'hD));
    // 2: successful CHECK keeps state=10 for 10 cycles
    btn_check = 1'b1;
    cyc(6);
    chk("t2_pre", 32'(state), 32'(2'b00));
    cyc(1);
    chk("t2_first", 32'(state), 32'(2'b10));
    cyc(9);
    chk("t2_last", 32'(state), 32'(2'b10));
    chk("t2_fail", 32'(fail_cnt), 32'(8'd0));
    chk("t2_lock", 32'(locked_out), 32'(1'b0));
    cyc(1);
    chk("t2_end", 32'(state), 32'(2'b00));
    btn_check = 1'b0;
    cyc(8);
    // 3: three failures with code 3 lead to a 20-cycle lockout
    press_set(4'h3);
    fail_check(8'd1, 1'b0);
    cyc(8);
    fail_check(8'd2, 1'b0);
    cyc(8);
    fail_check(8'd3, 1'b1);
    sw_num = 4'hD;
    btn_set = 1'b1;
    cyc(8);
    chk("t3_set_ign", 32'(ps_num), 32'(4'h3));
    chk("t3_set_state", 32'(state), 32'(2'b00));
    btn_set = 1'b0;
    btn_check = 1'b1;
    cyc(10);
    chk("t3_lock18", 32'(locked_out), 32'(1'b1));
    chk("t3_state18", 32'(state), 32'(2'b00));
    chk("t3_fail18", 32'(fail_cnt), 32'(8'd3));
    cyc(1);
    chk("t3_lock19", 32'(locked_out), 32'(1'b1));
    cyc(1);
    chk("t3_unlock", 32'(locked_out), 32'(1'b0));
    chk("t3_fail0", 32'(fail_cnt), 32'(8'd0));
    chk("t3_state", 32'(state), 32'(2'b00));
    btn_check = 1'b0;
    cyc(2);
    chk("t3_noqueue", 32'(state), 32'(2'b00));
    cyc(8);
    chk("t3_noqueue2", 32'(state), 32'(2'b00));
    // 4: bouncing SET is rejected; simultaneous presses give SET only
    sw_num = 4'hA;
    for (int i = 0; i < 10; i++) begin
      btn_set = ~btn_set;
      cyc(2);
      chk("t4_bounce", 32'(state), 32'(2'b00));
    end
    cyc(8);
    chk("t4_ps", 32'(ps_num), 32'(4'h3));
    sw_num = 4'hD;
    btn_set = 1'b1;
    btn_check = 1'b1;
    cyc(7);
    chk("t4_both_set", 32'(state), 32'(2'b01));
    chk("t4_both_ps", 32'(ps_num), 32'(4'hD));
    cyc(1);
    chk("t4_both_idle", 32'(state), 32'(2'b00));
    cyc(1);
    chk("t4_no_chk", 32'(state), 32'(2'b00));
    cyc(10);
    chk("t4_no_chk2", 32'(state), 32'(2'b00));
    btn_set = 1'b0;
    btn_check = 1'b0;
    cyc(8);
    // 5: asynchronous reset mid-OPEN and mid-LOCKOUT
    btn_check = 1'b1;
    cyc(7);
    chk("t5_chk", 32'(state), 32'(2'b10));
    btn_check = 1'b0;
    cyc(5);
    chk("t5_open", 32'(state), 32'(2'b10));
    rst_n = 1'b0;
    #1;
    all_idle("t5_rst_open");
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    press_set(4'h3);
    fail_check(8'd1, 1'b0);
    cyc(8);
    fail_check(8'd2, 1'b0);
    cyc(8);
    fail_check(8'd3, 1'b1);
    cyc(5);
    chk("t5_in_lock", 32'(locked_out), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    all_idle("t5_rst_lock");
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    press_set(4'hD);
    // 6: SET during CHECK and CHECK during OPEN are dropped
    btn_check = 1'b1;
    cyc(1);
    sw_num = 4'h5;
    btn_set = 1'b1;
    cyc(3);
    btn_check = 1'b0;
    cyc(3);
    chk("t6_chk", 32'(state), 32'(2'b10));
    cyc(3);
    btn_check = 1'b1;
    btn_set = 1'b0;
    chk("t6_open", 32'(state), 32'(2'b10));
    chk("t6_ps", 32'(ps_num), 32'(4'hD));
    cyc(6);
    chk("t6_open_last", 32'(state), 32'(2'b10));
    cyc(1);
    chk("t6_idle", 32'(state), 32'(2'b00));
    cyc(1);
    chk("t6_noqueue", 32'(state), 32'(2'b00));
    cyc(5);
    chk("t6_still", 32'(state), 32'(2'b00));
    chk("t6_ps_end", 32'(ps_num), 32'(4'hD));
    chk("t6_fail", 32'(fail_cnt), 32'(8'd0));
    btn_check = 1'b0;
    cyc(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
